eclk_align_ctrl: RTL

//  Sequences ECLK-to-SCLK phase alignment: steps the PLL dynamic phase, resets and

---
 rtl/eclk_align_ctrl_pkg.sv | 22 ++
 rtl/eclk_align_ctrl_wait_cnt.sv | 30 +++
 rtl/eclk_align_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/eclk_align_ctrl_pkg.sv
// Shared definitions for the ECLK-to-SCLK phase alignment sequencer:
// FSM state encoding and the minimum jitter-filter settle time.
package eclk_align_ctrl_pkg;

  // Two 128-cycle jitter filter windows must elapse before status is trusted.
  localparam int MIN_WAIT = 256;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FRST   = 4'd1;
  localparam logic [3:0] ST_SETTLE = 4'd2;
  localparam logic [3:0] ST_SAMPLE = 4'd3;
  localparam logic [3:0] ST_STEP   = 4'd4;
  localparam logic [3:0] ST_BSTEP  = 4'd5;
  localparam logic [3:0] ST_BWAIT  = 4'd6;
  localparam logic [3:0] ST_DONE   = 4'd7;
  localparam logic [3:0] ST_FAIL   = 4'd8;

  function automatic logic state_is_busy(input logic [3:0] s);
    return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL));
  endfunction

endpackage

// File: rtl/eclk_align_ctrl_wait_cnt.sv
// Loadable down-counter with a terminal flag; paces the FRST, SETTLE and
// BWAIT intervals of the alignment sequencer.
module align_wait_cnt #(
  parameter int W = 9
) (
  input  logic         sclk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/eclk_align_ctrl.sv
// ECLK/SCLK alignment sequencer: steps the PLL dynamic phase up until the
// filtered status shows a 0->1 edge, then backs off a fixed number of steps.
module eclk_align_ctrl
  import eclk_align_ctrl_pkg::*;
#(
  parameter int PHASE_W     = 4,
  parameter int WAIT_CYCLES = MIN_WAIT,
  parameter int STEP_GAP    = 8,
  parameter int BACKOFF     = 4,
  parameter int MAX_ROT     = 2
) (
  input  logic               sclk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               status_filt,
  output logic               filt_reset,
  output logic               phase_step,
  output logic               phase_dir,
  output logic [PHASE_W-1:0] phase_pos,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  localparam int MAX_STEPS = MAX_ROT * (2 ** PHASE_W);
  localparam int STEP_W    = $clog2(MAX_STEPS + 1);
  localparam int CNT_MAX   = (WAIT_CYCLES > STEP_GAP) ? WAIT_CYCLES : STEP_GAP;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [STEP_W-1:0]  MAX_STEPS_L = STEP_W'(MAX_STEPS);
  localparam logic [PHASE_W-1:0] BACKOFF_L   = PHASE_W'(BACKOFF);
  localparam logic [CNT_W-1:0]   FRST_LOAD   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GAP_LOAD    = CNT_W'(STEP_GAP - 2);

  logic [3:0]         state, state_nxt;
  logic [STEP_W-1:0]  search_steps;
  logic [PHASE_W-1:0] backoff_cnt;
  logic               prev, first;

  logic               cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]   cnt_val;

  logic               edge_seen, backoff_done;

  assign edge_seen    = !prev && status_filt;
  assign backoff_done = (backoff_cnt == BACKOFF_L);

  align_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .sclk     (sclk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .tc       (cnt_tc)
  );

  // The counter is loaded with (interval - 1) on entry, so each timed state
  // lasts exactly one cycle per count value down to and including zero.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) begin
          state_nxt = ST_FRST;
          cnt_load  = 1'b1;
          cnt_val   = FRST_LOAD;
        end
      end
      ST_FRST: begin
        if (cnt_tc) begin
          state_nxt = ST_SETTLE;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_tc) state_nxt = ST_SAMPLE;
        else        cnt_en    = 1'b1;
      end
      ST_SAMPLE: begin
        if (first)                              state_nxt = ST_STEP;
        else if (edge_seen)                     state_nxt = ST_BSTEP;
        else if (search_steps == MAX_STEPS_L)   state_nxt = ST_FAIL;
        else                                    state_nxt = ST_STEP;
      end
      ST_STEP: begin
        state_nxt = ST_FRST;
        cnt_load  = 1'b1;
        cnt_val   = FRST_LOAD;
      end
      ST_BSTEP: begin
        if (backoff_done) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_BWAIT;
          cnt_load  = 1'b1;
          cnt_val   = GAP_LOAD;
        end
      end
      ST_BWAIT: begin
        if (cnt_tc) state_nxt = ST_BSTEP;
        else        cnt_en    = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      phase_pos    <= '0;
      search_steps <= '0;
      backoff_cnt  <= '0;
      prev         <= 1'b0;
      first        <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            search_steps <= '0;
            first        <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (first) begin
            prev  <= status_filt;
            first <= 1'b0;
          end else if (edge_seen) begin
            backoff_cnt <= '0;
          end else if (search_steps != MAX_STEPS_L) begin
            prev <= status_filt;
          end
        end
        ST_STEP: begin
          phase_pos    <= phase_pos + PHASE_W'(1);
          search_steps <= search_steps + STEP_W'(1);
        end
        ST_BSTEP: begin
          if (!backoff_done) begin
            phase_pos   <= phase_pos - PHASE_W'(1);
            backoff_cnt <= backoff_cnt + PHASE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the registered state, so they change only on sclk.
  assign busy       = state_is_busy(state);
  assign done       = (state == ST_DONE);
  assign fail       = (state == ST_FAIL);
  assign filt_reset = (state == ST_IDLE) || (state == ST_FRST);
  assign phase_step = (state == ST_STEP) || ((state == ST_BSTEP) && !backoff_done);
  assign phase_dir  = (state != ST_BSTEP);

endmodule
